// File: rtl/ctrl_decode.sv
// ctrl_decode: instruction decode stage between fetch and execute.
// Turns a 16-bit instruction into ALU op, branch code, register indices,
// immediate and control flags, held in a registered output stage with
// valid/ready handshakes on both sides. Also provides taken-branch flush,
// a HALT/RESUME state machine and a count of ops handed to execute.
module ctrl_decode #(
  parameter int DATA_W    = 16,
  parameter int ALUCTRL_W = 3,
  parameter int BRANCH_W  = 3,
  parameter int REG_W     = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_in_valid,
  output logic                 o_in_ready,
  input  logic [DATA_W-1:0]    i_instr,
  input  logic                 i_flush,
  input  logic                 i_resume,
  output logic                 o_out_valid,
  input  logic                 i_out_ready,
  output logic [ALUCTRL_W-1:0] o_aluctrl,
  output logic [BRANCH_W-1:0]  o_branch,
  output logic [REG_W-1:0]     o_rd,
  output logic [REG_W-1:0]     o_rs,
  output logic [REG_W-1:0]     o_rt,
  output logic [DATA_W-1:0]    o_imm,
  output logic                 o_alusrc,
  output logic                 o_regwrite,
  output logic                 o_memread,
  output logic                 o_memwrite,
  output logic                 o_halted,
  output logic [15:0]          o_issue_cnt
);

  localparam logic [DATA_W-1:0] HALT_INSTR = DATA_W'(16'h0FFF);

  typedef enum logic {S_RUN, S_HALTED} state_t;

  state_t               r_state;
  logic                 r_halted;
  logic                 r_out_valid;
  logic [ALUCTRL_W-1:0] r_aluctrl;
  logic [BRANCH_W-1:0]  r_branch;
  logic [REG_W-1:0]     r_rd, r_rs, r_rt;
  logic [DATA_W-1:0]    r_imm;
  logic                 r_alusrc, r_regwrite, r_memread, r_memwrite;
  logic [15:0]          r_issue_cnt;

  logic [3:0]           w_op;
  logic [ALUCTRL_W-1:0] w_aluctrl;
  logic [BRANCH_W-1:0]  w_branch;
  logic [DATA_W-1:0]    w_imm;
  logic                 w_alusrc, w_regwrite, w_memread, w_memwrite;
  logic                 w_in_ready, w_accept, w_is_halt, w_load, w_handoff;

  assign w_op      = i_instr[15:12];
  assign w_in_ready = (r_state == S_RUN) && (!r_out_valid || i_out_ready);
  assign w_accept  = i_in_valid && w_in_ready;
  assign w_is_halt = (i_instr == HALT_INSTR);
  // A flush drops whatever is accepted in the same cycle, HALT included.
  assign w_load    = w_accept && !w_is_halt && !i_flush;
  assign w_handoff = r_out_valid && i_out_ready;

  // Combinational opcode decode into ALU op, branch code, immediate and flags.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves one unassigned and infers a latch.
    w_aluctrl  = '0;
    w_branch   = '0;
    w_imm      = '0;
    w_alusrc   = 1'b0;
    w_regwrite = 1'b0;
    w_memread  = 1'b0;
    w_memwrite = 1'b0;
    case (w_op)
      4'h0: ;  // NOP: everything stays zero
      4'h1: begin w_aluctrl = ALUCTRL_W'(0); w_regwrite = 1'b1; end  // MOV
      4'h2: begin w_aluctrl = ALUCTRL_W'(1); w_regwrite = 1'b1; end  // ADD
      4'h3: begin w_aluctrl = ALUCTRL_W'(2); w_regwrite = 1'b1; end  // AND
      4'h4: begin w_aluctrl = ALUCTRL_W'(3); w_regwrite = 1'b1; end  // XOR
      4'h5: begin w_aluctrl = ALUCTRL_W'(4); w_regwrite = 1'b1; end  // OR
      4'h6: begin w_aluctrl = ALUCTRL_W'(5); w_regwrite = 1'b1; end  // NOT
      4'h7: begin w_aluctrl = ALUCTRL_W'(6); w_regwrite = 1'b1; end  // SHL
      4'h8: begin w_aluctrl = ALUCTRL_W'(7); w_regwrite = 1'b1; end  // SHR
      4'h9: begin  // ADDI
        w_aluctrl  = ALUCTRL_W'(1);
        w_regwrite = 1'b1;
        w_alusrc   = 1'b1;
        w_imm      = {{(DATA_W-4){1'b0}}, i_instr[3:0]};
      end
      4'hA: begin  // LD: address = rs + imm4
        w_aluctrl  = ALUCTRL_W'(1);
        w_regwrite = 1'b1;
        w_memread  = 1'b1;
        w_alusrc   = 1'b1;
        w_imm      = {{(DATA_W-4){1'b0}}, i_instr[3:0]};
      end
      4'hB: begin  // ST: address = rs + imm4, no register write-back
        w_aluctrl  = ALUCTRL_W'(1);
        w_memwrite = 1'b1;
        w_alusrc   = 1'b1;
        w_imm      = {{(DATA_W-4){1'b0}}, i_instr[3:0]};
      end
      4'hC: begin  // JMP: 12-bit signed offset
        w_branch = BRANCH_W'(1);
        w_imm    = {{(DATA_W-12){i_instr[11]}}, i_instr[11:0]};
      end
      4'hD: begin w_branch = BRANCH_W'(2); w_imm = {{(DATA_W-4){i_instr[3]}}, i_instr[3:0]}; end  // BGT
      4'hE: begin w_branch = BRANCH_W'(3); w_imm = {{(DATA_W-4){i_instr[3]}}, i_instr[3:0]}; end  // BLT
      4'hF: begin w_branch = BRANCH_W'(4); w_imm = {{(DATA_W-4){i_instr[3]}}, i_instr[3:0]}; end  // BEQ
    endcase
  end

  // RUN/HALTED state machine; HALT takes effect only if not flushed the same cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      r_state  <= S_RUN;
      r_halted <= 1'b0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (w_accept && w_is_halt && !i_flush) begin
            r_state  <= S_HALTED;
            r_halted <= 1'b1;
          end
        end
        S_HALTED: begin
          if (i_resume || i_flush) begin
            r_state  <= S_RUN;
            r_halted <= 1'b0;
          end
        end
      endcase
    end
  end

  // Output stage: load on a forwarded accept, hold while execute stalls.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_out_valid <= 1'b0;
      r_aluctrl   <= '0;
      r_branch    <= '0;
      r_rd        <= '0;
      r_rs        <= '0;
      r_rt        <= '0;
      r_imm       <= '0;
      r_alusrc    <= 1'b0;
      r_regwrite  <= 1'b0;
      r_memread   <= 1'b0;
      r_memwrite  <= 1'b0;
    end else begin
      if (i_flush)          r_out_valid <= 1'b0;
      else if (w_load)      r_out_valid <= 1'b1;
      else if (i_out_ready) r_out_valid <= 1'b0;

      if (w_load) begin
        r_aluctrl  <= w_aluctrl;
        r_branch   <= w_branch;
        r_rd       <= i_instr[11:8];
        r_rs       <= i_instr[7:4];
        r_rt       <= i_instr[3:0];
        r_imm      <= w_imm;
        r_alusrc   <= w_alusrc;
        r_regwrite <= w_regwrite;
        r_memread  <= w_memread;
        r_memwrite <= w_memwrite;
      end
    end
  end

  // Issue counter: every output handshake counts, even in a flush cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)          r_issue_cnt <= '0;
    else if (w_handoff) r_issue_cnt <= r_issue_cnt + 16'd1;
  end

  assign o_in_ready  = w_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_aluctrl   = r_aluctrl;
  assign o_branch    = r_branch;
  assign o_rd        = r_rd;
  assign o_rs        = r_rs;
  assign o_rt        = r_rt;
  assign o_imm       = r_imm;
  assign o_alusrc    = r_alusrc;
  assign o_regwrite  = r_regwrite;
  assign o_memread   = r_memread;
  assign o_memwrite  = r_memwrite;
  assign o_halted    = r_halted;
  assign o_issue_cnt = r_issue_cnt;

endmodule
